// File: rtl/pipe_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_stage
// Purpose  : MEM stage between EX/MEM and MEM/WB. Provides a req/ack handshake
//            to variable-latency data memory, byte-lane store/load steering,
//            alignment checking, a wait timeout and a pipeline stall output.
// Options  : MEM_PERF_CNT_EN - enables the saturating stall-cycle counter
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mem_stage #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int RF_ADDRESS = 5,
  parameter int TO_W       = 8,
  parameter int MAX_WAIT   = 200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_valid,
  input  logic                    ex_MemRead,
  input  logic                    ex_MemWrite,
  input  logic [2:0]              ex_func3,
  input  logic                    ex_RegWrite,
  input  logic [RF_ADDRESS-1:0]   ex_rd,
  input  logic [DATA_W-1:0]       ex_alu_result,
  input  logic [DATA_W-1:0]       ex_wr_data,
  output logic                    mem_stall,
  output logic                    dm_req,
  output logic                    dm_we,
  output logic [DM_ADDRESS-1:0]   dm_addr,
  output logic [DATA_W/8-1:0]     dm_be,
  output logic [DATA_W-1:0]       dm_wdata,
  input  logic                    dm_ack,
  input  logic [DATA_W-1:0]       dm_rdata,
  output logic                    wb_valid,
  output logic                    wb_RegWrite,
  output logic [RF_ADDRESS-1:0]   wb_rd,
  output logic [DATA_W-1:0]       wb_data,
  output logic                    misalign,
  output logic                    timeout,
  output logic [31:0]             perf_stall_cnt
);

  localparam int              LANES      = DATA_W / 8;
  localparam int              LW         = $clog2(LANES);
  localparam logic            c_is64     = (DATA_W == 64);
  localparam logic [TO_W-1:0] c_cnt_last = TO_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                  r_state;
  logic [TO_W-1:0]         r_cnt;
  logic [2:0]              r_func3;
  logic [LW-1:0]           r_lane;
  logic [RF_ADDRESS-1:0]   r_rd;
  logic                    r_regwrite;
  logic [DATA_W-1:0]       r_alu;

  logic                    w_mem_op;
  logic                    w_err;
  logic                    w_cnt_last;
  logic                    w_issue;
  logic [LW-1:0]           w_lane;
  logic [DM_ADDRESS-1:0]   w_addr;
  logic [LANES-1:0]        w_be;
  logic [DATA_W-1:0]       w_wdata;

  assign w_mem_op   = ex_MemRead | ex_MemWrite;
  assign w_lane     = ex_alu_result[LW-1:0];
  assign w_addr     = {ex_alu_result[DM_ADDRESS-1:LW], {LW{1'b0}}};
  assign w_cnt_last = (r_cnt == c_cnt_last);
  assign w_issue    = ex_valid & w_mem_op & ~w_err;

  // Alignment and funct3 legality; 1xx encodings are load-only.
  always_comb begin
    w_err = 1'b0;
    case (ex_func3)
      3'b000:  w_err = 1'b0;
      3'b001:  w_err = w_lane[0];
      3'b010:  w_err = (w_lane[1:0] != 2'b00);
      3'b011:  w_err = ~c_is64 | (w_lane != '0);
      3'b100:  w_err = ex_MemWrite;
      3'b101:  w_err = ex_MemWrite | w_lane[0];
      3'b110:  w_err = ex_MemWrite | ~c_is64 | (w_lane != '0);
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = '1;
    w_wdata = ex_wr_data;
    case (ex_func3[1:0])
      2'b00: begin
        w_be    = LANES'(1) << w_lane;
        w_wdata = {LANES{ex_wr_data[7:0]}};
      end
      2'b01: begin
        w_be    = LANES'(3) << w_lane;
        w_wdata = {(LANES/2){ex_wr_data[15:0]}};
      end
      2'b10: begin
        w_be    = LANES'(15) << w_lane;
        w_wdata = {(LANES/4){ex_wr_data[31:0]}};
      end
      default: begin
        w_be    = '1;
        w_wdata = ex_wr_data;
      end
    endcase
  end

  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] rdata,
    input logic [2:0]        f3,
    input logic [LW-1:0]     lane
  );
    logic [DATA_W-1:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (f3)
      3'b000:  load_extract = DATA_W'($signed(sh[7:0]));
      3'b001:  load_extract = DATA_W'($signed(sh[15:0]));
      3'b010:  load_extract = DATA_W'($signed(sh[31:0]));
      3'b100:  load_extract = DATA_W'(sh[7:0]);
      3'b101:  load_extract = DATA_W'(sh[15:0]);
      3'b110:  load_extract = DATA_W'(sh[31:0]);
      default: load_extract = sh;
    endcase
  endfunction

  // Stall/error pulses are same-cycle decisions; forced low while in reset.
  always_comb begin
    mem_stall = 1'b0;
    misalign  = 1'b0;
    timeout   = 1'b0;
    if (reset) begin
      case (r_state)
        S_IDLE: begin
          mem_stall = w_issue;
          misalign  = ex_valid & w_mem_op & w_err;
        end
        S_WAIT: begin
          mem_stall = ~dm_ack & ~w_cnt_last;
          timeout   = ~dm_ack & w_cnt_last;
        end
        default: begin
          mem_stall = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_func3     <= '0;
      r_lane      <= '0;
      r_rd        <= '0;
      r_regwrite  <= 1'b0;
      r_alu       <= '0;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_be       <= '0;
      dm_wdata    <= '0;
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!ex_valid) begin
            wb_valid <= 1'b0;
          end else if (!w_mem_op || w_err) begin
            wb_valid    <= 1'b1;
            wb_RegWrite <= ex_RegWrite & ~w_mem_op;
            wb_rd       <= ex_rd;
            wb_data     <= ex_alu_result;
          end else begin
            wb_valid   <= 1'b0;
            r_func3    <= ex_func3;
            r_lane     <= w_lane;
            r_rd       <= ex_rd;
            r_regwrite <= ex_RegWrite;
            r_alu      <= ex_alu_result;
            dm_req     <= 1'b1;
            dm_we      <= ex_MemWrite;
            dm_addr    <= w_addr;
            dm_be      <= w_be;
            dm_wdata   <= w_wdata;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dm_ack || w_cnt_last) begin
            // Ack has priority over an expiring timeout in the same cycle.
            wb_valid    <= 1'b1;
            wb_RegWrite <= r_regwrite & dm_ack;
            wb_rd       <= r_rd;
            wb_data     <= (dm_ack && !dm_we) ? load_extract(dm_rdata, r_func3, r_lane)
                                              : r_alu;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
    end else if (mem_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
